mem_bus_arbiter: RTL and testbench

Shares the single data-memory port of the multicycle RISC-V core between two masters: M0, the CPU datapath (instruction fetch and load/store), and M1, a secondary master (bootloader/debug/DMA).
- Sequences each access as issue, wait, complete.
- Asserts a stall toward the multicycle control FSM while the CPU is waiting.
- Sits between the datapath's memory-bus outputs and the RAM bus.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 104 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory bus arbiter.
// Holds the FSM state encoding, master IDs, bus widths and the latched
// command record used between arbitration and issue.
package mem_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int LAT_W  = 4;  // MEM_LATENCY is limited to 1..15

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic [BE_W-1:0]   be;
  } cmd_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for the arbiter: two requesting masters plus the RAM port.
// Modport slave is the arbiter side; modport master is the environment
// (CPU datapath, secondary master and RAM) side.
interface mem_bus_arbiter_if;
  import mem_arb_pkg::*;

  logic              iM0Req, iM0Write, oM0Done;
  logic [ADDR_W-1:0] iM0Addr;
  logic [DATA_W-1:0] iM0WData, oM0RData;
  logic [BE_W-1:0]   iM0BE;

  logic              iM1Req, iM1Write, oM1Done;
  logic [ADDR_W-1:0] iM1Addr;
  logic [DATA_W-1:0] iM1WData, oM1RData;
  logic [BE_W-1:0]   iM1BE;

  logic [ADDR_W-1:0] oMemAddress;
  logic [DATA_W-1:0] oMemWData, iMemRData;
  logic              oMemWE, oMemRE;
  logic [BE_W-1:0]   oMemBE;

  logic              oOwner, oCpuStall;

  modport slave (
    input  iM0Req, iM0Addr, iM0WData, iM0Write, iM0BE,
    output oM0Done, oM0RData,
    input  iM1Req, iM1Addr, iM1WData, iM1Write, iM1BE,
    output oM1Done, oM1RData,
    output oMemAddress, oMemWData, oMemWE, oMemRE, oMemBE,
    input  iMemRData,
    output oOwner, oCpuStall
  );

  modport master (
    output iM0Req, iM0Addr, iM0WData, iM0Write, iM0BE,
    input  oM0Done, oM0RData,
    output iM1Req, iM1Addr, iM1WData, iM1Write, iM1BE,
    input  oM1Done, oM1RData,
    input  oMemAddress, oMemWData, oMemWE, oMemRE, oMemBE,
    output iMemRData,
    input  oOwner, oCpuStall
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory bus arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects strict alternation on ties;
// otherwise fixed priority to M0 with a starvation bound for M1.
// Ports: req0/req1 requests, wait_cnt lost-arbitration count of M1,
// last_grant previous winner, grant winning master index.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic              req0,
  input  logic              req1,
  input  logic [WAIT_W-1:0] wait_cnt,
  input  logic              last_grant,
  output logic              grant
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic unused_pick;
  assign unused_pick = ^wait_cnt;

  // Tie goes to whoever did not win last time.
  always_comb begin
    grant = M_CPU;
    if (req0 && req1) grant = ~last_grant;
    else if (req1)    grant = M_AUX;
  end
`else
  logic unused_pick;
  assign unused_pick = last_grant;

  // M1 wins alone, or once it has lost MAX_WAIT ties in a row.
  always_comb begin
    grant = M_CPU;
    if (req1 && (!req0 || wait_cnt == WAIT_W'(MAX_WAIT))) grant = M_AUX;
  end
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data-memory port between the CPU datapath (M0) and a
// secondary master (M1). Each access runs IDLE -> ISSUE -> [WAIT] -> DONE.
// Build option: MEM_ARB_ROUND_ROBIN_EN (strict alternation on ties).
// Ports: iCLK clock, iRST synchronous active-low reset, bus arbiter-side
// bundle (master requests/completions, RAM port, owner and CPU stall).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic               iCLK,
  input  logic               iRST,
  mem_bus_arbiter_if.slave   bus
);
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  state_e              state, state_nxt;
  cmd_t                cmd;
  logic                owner, last_grant, grant, any_req, done0, done1;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [DATA_W-1:0]   rdata0, rdata1;

  assign any_req = bus.iM0Req | bus.iM1Req;

  mem_arb_pick #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_pick (
    .req0       (bus.iM0Req),
    .req1       (bus.iM1Req),
    .wait_cnt   (wait_cnt),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // State register
  always_ff @(posedge iCLK) begin
    if (!iRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = cmd.write ? DONE : WAIT;
      WAIT:    if (lat_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, counters and read-data capture
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      cmd        <= '0;
      owner      <= M_CPU;
      last_grant <= M_AUX;  // so M0 takes the first tie under alternation
      wait_cnt   <= '0;
      lat_cnt    <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        cmd        <= (grant == M_AUX)
                      ? '{bus.iM1Addr, bus.iM1WData, bus.iM1Write, bus.iM1BE}
                      : '{bus.iM0Addr, bus.iM0WData, bus.iM0Write, bus.iM0BE};
        owner      <= grant;
        last_grant <= grant;
        if (grant == M_AUX)
          wait_cnt <= '0;
        else if (bus.iM1Req && wait_cnt != WAIT_W'(MAX_WAIT))
          wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == ISSUE) lat_cnt <= LAT_W'(MEM_LATENCY - 1);
      if (state == WAIT) begin
        if (lat_cnt == '0) begin
          if (owner == M_AUX) rdata1 <= bus.iMemRData;
          else                rdata0 <= bus.iMemRData;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
      end
    end
  end

  // Outputs; address/data/BE come straight from the command latch so they
  // stay stable through WAIT and read as zero after reset.
  always_comb begin
    done0           = (state == DONE) && (owner == M_CPU);
    done1           = (state == DONE) && (owner == M_AUX);
    bus.oMemAddress = cmd.addr;
    bus.oMemWData   = cmd.wdata;
    bus.oMemBE      = cmd.be;
    bus.oMemWE      = (state == ISSUE) &&  cmd.write;
    bus.oMemRE      = (state == ISSUE) && !cmd.write;
    bus.oM0Done     = done0;
    bus.oM1Done     = done1;
    bus.oM0RData    = rdata0;
    bus.oM1RData    = rdata1;
    bus.oOwner      = owner;
    bus.oCpuStall   = bus.iM0Req & ~done0;
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int LAT = 2;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic iCLK = 1'b0;
  logic iRST;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 iCLK = ~iCLK;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.MEM_LATENCY(LAT), .MAX_WAIT(4)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [5:0] gexp;

  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    gexp = 6'b101010;  // bit g = owner of grant g
`else
    gexp = 6'b010000;
`endif
    // Reset with both masters requesting
    iRST = 1'b0;
    bus.iM0Req = 1'b1; bus.iM0Addr = 32'h0040_0010; bus.iM0WData = 32'h0;
    bus.iM0Write = 1'b0; bus.iM0BE = 4'hF;
    bus.iM1Req = 1'b1; bus.iM1Addr = 32'h1001_0000; bus.iM1WData = 32'h0000_00AB;
    bus.iM1Write = 1'b1; bus.iM1BE = 4'b0001;
    bus.iMemRData = BAD;
    tick(); tick();
    chk("rst_re",    32'(bus.oMemRE), 32'h0);
    chk("rst_we",    32'(bus.oMemWE), 32'h0);
    chk("rst_owner", 32'(bus.oOwner), 32'h0);
    chk("rst_done0", 32'(bus.oM0Done), 32'h0);
    chk("rst_done1", 32'(bus.oM1Done), 32'h0);
    chk("rst_addr",  bus.oMemAddress, 32'h0);
    chk("rst_rd0",   bus.oM0RData, 32'h0);

    // t: IDLE, M0 read wins over M1 write
    iRST = 1'b1;
    chk("t0_re", 32'(bus.oMemRE), 32'h0);
    chk("t0_stall", 32'(bus.oCpuStall), 32'h1);
    tick(); // t+1 ISSUE
    chk("t1_re",    32'(bus.oMemRE), 32'h1);
    chk("t1_we",    32'(bus.oMemWE), 32'h0);
    chk("t1_owner", 32'(bus.oOwner), 32'h0);
    chk("t1_addr",  bus.oMemAddress, 32'h0040_0010);
    chk("t1_stall", 32'(bus.oCpuStall), 32'h1);
    tick(); // t+2 WAIT
    chk("t2_re",    32'(bus.oMemRE), 32'h0);
    chk("t2_addr",  bus.oMemAddress, 32'h0040_0010);
    chk("t2_stall", 32'(bus.oCpuStall), 32'h1);
    tick(); // t+3 WAIT, data valid now
    bus.iMemRData = 32'hDEAD_BEEF;
    chk("t3_done0", 32'(bus.oM0Done), 32'h0);
    chk("t3_stall", 32'(bus.oCpuStall), 32'h1);
    tick(); // t+4 DONE
    bus.iMemRData = BAD;
    chk("t4_done0", 32'(bus.oM0Done), 32'h1);
    chk("t4_rd0",   bus.oM0RData, 32'hDEAD_BEEF);
    chk("t4_stall", 32'(bus.oCpuStall), 32'h0);
    bus.iM0Req = 1'b0;
    tick(); // IDLE, only M1 pending
    chk("m1_idle_done0", 32'(bus.oM0Done), 32'h0);
    tick(); // M1 write ISSUE
    chk("m1_we",    32'(bus.oMemWE), 32'h1);
    chk("m1_re",    32'(bus.oMemRE), 32'h0);
    chk("m1_owner", 32'(bus.oOwner), 32'h1);
    chk("m1_addr",  bus.oMemAddress, 32'h1001_0000);
    chk("m1_wdata", bus.oMemWData, 32'h0000_00AB);
    chk("m1_be",    32'(bus.oMemBE), 32'h1);
    tick(); // DONE
    chk("m1_done1", 32'(bus.oM1Done), 32'h1);
    chk("m1_done0", 32'(bus.oM0Done), 32'h0);
    chk("m1_we_off", 32'(bus.oMemWE), 32'h0);
    bus.iM1Req = 1'b0;
    tick(); // IDLE
    chk("m1_done1_off", 32'(bus.oM1Done), 32'h0);
    chk("m1_rd0_kept",  bus.oM0RData, 32'hDEAD_BEEF);

    // Back-to-back M0 reads, Req held through DONE
    bus.iM0Req = 1'b1; bus.iM0Addr = 32'h0000_0100;
    tick(); // ISSUE
    chk("bb1_re", 32'(bus.oMemRE), 32'h1);
    tick(); // WAIT
    tick(); // WAIT
    bus.iMemRData = 32'h1111_2222;
    chk("bb1_rd_hold", bus.oM0RData, 32'hDEAD_BEEF);
    tick(); // DONE
    bus.iMemRData = BAD;
    chk("bb1_done", 32'(bus.oM0Done), 32'h1);
    chk("bb1_rd",   bus.oM0RData, 32'h1111_2222);
    bus.iM0Addr = 32'h0000_0200;
    tick(); // IDLE
    chk("bb_gap_re",   32'(bus.oMemRE), 32'h0);
    chk("bb_gap_done", 32'(bus.oM0Done), 32'h0);
    tick(); // ISSUE, two cycles after first Done
    chk("bb2_re",   32'(bus.oMemRE), 32'h1);
    chk("bb2_addr", bus.oMemAddress, 32'h0000_0200);
    tick(); // WAIT
    chk("bb2_rd_hold", bus.oM0RData, 32'h1111_2222);
    tick(); // WAIT
    bus.iMemRData = 32'h3333_4444;
    tick(); // DONE
    bus.iMemRData = BAD;
    chk("bb2_done", 32'(bus.oM0Done), 32'h1);
    chk("bb2_rd",   bus.oM0RData, 32'h3333_4444);
    bus.iM0Req = 1'b0;
    tick(); // IDLE

    // Reset during WAIT aborts the read
    bus.iM0Req = 1'b1; bus.iM0Addr = 32'h0000_0050;
    tick(); // ISSUE
    tick(); // WAIT
    iRST = 1'b0;
    tick();
    chk("abort_re",    32'(bus.oMemRE), 32'h0);
    chk("abort_we",    32'(bus.oMemWE), 32'h0);
    chk("abort_done0", 32'(bus.oM0Done), 32'h0);
    chk("abort_rd0",   bus.oM0RData, 32'h0);
    chk("abort_addr",  bus.oMemAddress, 32'h0);
    iRST = 1'b1;
    bus.iM0Req = 1'b0;
    tick();
    chk("abort_done0_a", 32'(bus.oM0Done), 32'h0);
    tick();
    chk("abort_done0_b", 32'(bus.oM0Done), 32'h0);

    // Both masters request writes continuously
    bus.iM0Req = 1'b1; bus.iM0Write = 1'b1; bus.iM0Addr = 32'h0000_1000;
    bus.iM1Req = 1'b1; bus.iM1Write = 1'b1; bus.iM1Addr = 32'h0000_2000;
    for (int g = 0; g < 6; g++) begin
      tick(); // ISSUE
      chk($sformatf("grant%0d_owner", g), 32'(bus.oOwner), 32'(gexp[g]));
      chk($sformatf("grant%0d_addr", g), bus.oMemAddress,
          gexp[g] ? 32'h0000_2000 : 32'h0000_1000);
      tick(); // DONE
      tick(); // IDLE
    end
    bus.iM0Req = 1'b0; bus.iM1Req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
